program_counter_stack: RTL and testbench
========================================

// Module: program_counter_stack
// PURPOSE
//   Parametrised program counter that owns the PC register internally and
//   resolves increment, relative-branch, absolute-jump, call and return in one
//   cycle. It adds a DEPTH-entry return-address stack with overflow and
//   underflow detection. It sits between decode (op/offset/target) and
//   instruction fetch (pc).
// PARAMETERS
//   W          6   PC / address width in bits; all PC arithmetic is modulo 2^W
//   DEPTH      4   return-stack entries (>=1)
//   RESET_VEC  0   PC value loaded on reset (W bits)
// PORTS
//   clk        in   1               clock; all state updates on posedge
//   rst_n      in   1               synchronous, active-low reset
//   en         in   1               update enable; 0 = hold all state
//   op         in   3               0 INC, 1 REL, 2 ABS, 3 CALL_REL, 4 CALL_ABS, 5 RET, 6-7 reserved
//   offset     in   W               unsigned offset for REL / CALL_REL
//   target     in   W               absolute address for ABS / CALL_ABS
//   clr_err    in   1               clears the sticky error flags
//   pc         out  W               current PC (registered)
//   depth      out  clog2(DEPTH+1)  number of valid stack entries
//   stk_full   out  1               depth == DEPTH
//   stk_empty  out  1               depth == 0
//   ovf_err    out  1               sticky: a CALL was issued while full
//   unf_err    out  1               sticky: a RET was issued while empty
//   bad_op     out  1               sticky: a reserved op was issued while en=1
// BEHAVIOUR
// - Reset (rst_n=0 at posedge, has priority over everything):
//   - pc=RESET_VEC, depth=0, all error flags 0.
//   - Stack contents are don't-care.
// - en=0: pc, depth and stack hold. Error flags hold unless clr_err is high.
// - en=1: the update is visible on pc one cycle later (1-cycle latency).
//   "seq" below denotes pc+1.
//   - INC: pc <= pc+1.
//   - REL: pc <= pc+offset+1.
//   - ABS: pc <= target.
//   - CALL_REL, not full: push seq; pc <= pc+offset+1; depth+1.
//   - CALL_ABS, not full: push seq; pc <= target; depth+1.
//   - CALL_* while full: no push, pc holds, depth holds, ovf_err <= 1.
//   - RET, not empty: pc <= top entry; depth-1.
//   - RET while empty: pc holds, unf_err <= 1.
//   - op 6/7: pc and stack hold, bad_op <= 1.
// - Arithmetic: sums are truncated to W bits with silent wrap
//   (e.g. 63+1 -> 0 and 60+3+1 -> 0 for W=6). Carry is discarded.
// - Stack: LIFO register file indexed by depth; top entry = entry[depth-1].
//   Only one push or pop occurs per cycle.
// - stk_full, stk_empty and depth are decoded from the registered depth
//   and are valid in the same cycle as pc.
// - Error flags:
//   - Set-dominant: if clr_err and a set event occur in the same cycle,
//     the flag ends at 1.
//   - clr_err takes effect regardless of en.
// - Reset asserted in the same cycle as en=1 with any op: reset wins.
//   No push occurs and no error flag is set.
// TESTING (W=6, DEPTH=4, RESET_VEC=0)
// 1. Reset, then en=1 INC x3 -> pc 1,2,3. Then en=0 for 2 cycles -> pc stays 3.
// 2. ABS target=60, then REL offset=3 -> pc 0 (wrap).
//    ABS 63, then INC -> pc 0.
//    ABS 12, then REL offset=8 -> pc 21.
// 3. ABS 5, then CALL_REL offset=10 -> pc 16, depth 1.
//    Then RET -> pc 6, depth 0, stk_empty=1.
// 4. Four CALL_ABS targets 10,20,30,40 -> depth 4, stk_full=1, pc 40.
//    Fifth CALL_ABS target 50 -> pc 40, depth 4, ovf_err=1.
//    Then RET x4 -> pc returns in LIFO order: 31, 21, 11, then the
//    return address of the first call.
// 5. From empty: RET -> pc unchanged, unf_err=1. Then op=7 -> bad_op=1.
//    Then clr_err with en=0 -> all flags 0.
//    Then clr_err together with RET on empty -> unf_err=1.
// 6. Mid-sequence (depth 2, ovf_err=1): drive rst_n=0 together with en=1
//    CALL_ABS -> next edge pc=0, depth 0, all flags 0.
//    Then after release, INC -> pc 1.

Source files
------------

// File: rtl/program_counter_stack.sv
// Program counter with one-cycle INC/REL/ABS/CALL/RET resolution and a LIFO
// return-address stack that raises sticky overflow/underflow/bad-op flags.

module program_counter_stack_entry #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module program_counter_stack #(
  parameter int           W         = 6,
  parameter int           DEPTH     = 4,
  parameter logic [W-1:0] RESET_VEC = '0,
  localparam int          DW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [W-1:0]  offset,
  input  logic [W-1:0]  target,
  input  logic          clr_err,
  output logic [W-1:0]  pc,
  output logic [DW-1:0] depth,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          ovf_err,
  output logic          unf_err,
  output logic          bad_op
);

  typedef enum logic [2:0] {
    OP_INC      = 3'd0,
    OP_REL      = 3'd1,
    OP_ABS      = 3'd2,
    OP_CALL_REL = 3'd3,
    OP_CALL_ABS = 3'd4,
    OP_RET      = 3'd5
  } op_e;

  typedef struct packed {
    logic push;
    logic pop;
    logic set_ovf;
    logic set_unf;
    logic set_bad;
  } ctl_t;

  logic [DEPTH-1:0][W-1:0] stk_q;
  logic [W-1:0]            seq, rel, top, pc_nxt;
  ctl_t                    ctl;

  assign stk_full  = (depth == DW'(DEPTH));
  assign stk_empty = (depth == '0);
  assign seq       = pc + W'(1);
  assign rel       = pc + offset + W'(1);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth == DW'(i + 1)) top = stk_q[i];
  end

  always_comb begin
    pc_nxt = pc;
    ctl    = '0;
    if (en) begin
      case (op)
        OP_INC: pc_nxt = seq;
        OP_REL: pc_nxt = rel;
        OP_ABS: pc_nxt = target;
        OP_CALL_REL, OP_CALL_ABS: begin
          if (stk_full) begin
            ctl.set_ovf = 1'b1;
          end else begin
            ctl.push = 1'b1;
            pc_nxt   = (op == OP_CALL_REL) ? rel : target;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            ctl.set_unf = 1'b1;
          end else begin
            ctl.pop = 1'b1;
            pc_nxt  = top;
          end
        end
        default: ctl.set_bad = 1'b1;
      endcase
    end
  end

  // Push writes the slot just above the current top; reset masks the write.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stk
    program_counter_stack_entry #(.W(W)) u_entry (
      .clk (clk),
      .we  (rst_n && ctl.push && (depth == DW'(g))),
      .d   (seq),
      .q   (stk_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_VEC;
      depth   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
      bad_op  <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (ctl.push)     depth <= depth + DW'(1);
      else if (ctl.pop) depth <= depth - DW'(1);
      // Set-dominant sticky flags; clear works even with en low.
      ovf_err <= ctl.set_ovf | (ovf_err & ~clr_err);
      unf_err <= ctl.set_unf | (unf_err & ~clr_err);
      bad_op  <= ctl.set_bad | (bad_op  & ~clr_err);
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench for program_counter_stack (W=6, DEPTH=4, RESET_VEC=0).

module tb_program_counter_stack;
  localparam int W = 6;
  localparam int DEPTH = 4;
  localparam int DW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  offset = '0;
  logic [W-1:0]  target = '0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  pc;
  logic [DW-1:0] depth;
  logic          stk_full, stk_empty, ovf_err, unf_err, bad_op;

  program_counter_stack #(.W(W), .DEPTH(DEPTH), .RESET_VEC('0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .offset(offset),
    .target(target), .clr_err(clr_err), .pc(pc), .depth(depth),
    .stk_full(stk_full), .stk_empty(stk_empty), .ovf_err(ovf_err),
    .unf_err(unf_err), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  pc;
    logic [DW-1:0] depth;
    logic          full, empty, ovf, unf, bad;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_ovf, m_unf, m_bad;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model of the next-state behaviour.
  task automatic model(input bit r_n, input bit e, input logic [2:0] o,
                       input logic [W-1:0] off, input logic [W-1:0] tgt, input bit clr);
    if (!r_n) begin
      m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_bad = 0;
    end else begin
      if (clr) begin m_ovf = 0; m_unf = 0; m_bad = 0; end
      if (e) begin
        case (o)
          3'd0: m_pc = W'(m_pc + 1);
          3'd1: m_pc = W'(m_pc + off + 1);
          3'd2: m_pc = tgt;
          3'd3, 3'd4: begin
            if (m_stk.size() == DEPTH) m_ovf = 1;
            else begin
              m_stk.push_back(W'(m_pc + 1));
              m_pc = (o == 3'd3) ? W'(m_pc + off + 1) : tgt;
            end
          end
          3'd5: begin
            if (m_stk.size() == 0) m_unf = 1;
            else m_pc = m_stk.pop_back();
          end
          default: m_bad = 1;
        endcase
      end
    end
  endtask

  task automatic step(input bit r_n, input bit e, input logic [2:0] o,
                      input logic [W-1:0] off, input logic [W-1:0] tgt, input bit clr);
    exp_t x;
    @(negedge clk);
    rst_n = r_n; en = e; op = o; offset = off; target = tgt; clr_err = clr;
    model(r_n, e, o, off, tgt, clr);
    x.pc = m_pc; x.depth = DW'(m_stk.size());
    x.full = (m_stk.size() == DEPTH); x.empty = (m_stk.size() == 0);
    x.ovf = m_ovf; x.unf = m_unf; x.bad = m_bad;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk("pc", 32'(pc), 32'(x.pc));
    chk("depth", 32'(depth), 32'(x.depth));
    chk("stk_full", 32'(stk_full), 32'(x.full));
    chk("stk_empty", 32'(stk_empty), 32'(x.empty));
    chk("ovf_err", 32'(ovf_err), 32'(x.ovf));
    chk("unf_err", 32'(unf_err), 32'(x.unf));
    chk("bad_op", 32'(bad_op), 32'(x.bad));
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] off, input logic [W-1:0] tgt);
    step(1, 1, o, off, tgt, 0);
  endtask

  initial begin
    // 1: reset, INC x3, hold
    step(0, 0, 0, 0, 0, 0);
    chk("reset_pc", 32'(pc), 0);
    for (int i = 0; i < 3; i++) run(0, 0, 0);
    chk("inc3_pc", 32'(pc), 3);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 9, 9, 0);
    chk("hold_pc", 32'(pc), 3);
    // 2: wrap arithmetic
    run(2, 0, 60); run(1, 3, 0);
    chk("rel_wrap", 32'(pc), 0);
    run(2, 0, 63); run(0, 0, 0);
    chk("inc_wrap", 32'(pc), 0);
    run(2, 0, 12); run(1, 8, 0);
    chk("rel_pc", 32'(pc), 21);
    // 3: call/return
    run(2, 0, 5); run(3, 10, 0);
    chk("call_rel_pc", 32'(pc), 16);
    run(5, 0, 0);
    chk("ret_pc", 32'(pc), 6);
    // 4: fill, overflow, unwind
    run(4, 0, 10); run(4, 0, 20); run(4, 0, 30); run(4, 0, 40);
    chk("full", 32'(stk_full), 1);
    run(4, 0, 50);
    chk("ovf_pc", 32'(pc), 40);
    chk("ovf_set", 32'(ovf_err), 1);
    run(5, 0, 0); chk("ret1", 32'(pc), 31);
    run(5, 0, 0); chk("ret2", 32'(pc), 21);
    run(5, 0, 0); chk("ret3", 32'(pc), 11);
    run(5, 0, 0); chk("ret4", 32'(pc), 7);
    // 5: underflow, bad op, clear, set-dominant clear
    step(1, 0, 0, 0, 0, 1);
    run(5, 0, 0);
    chk("unf_pc", 32'(pc), 7);
    chk("unf_set", 32'(unf_err), 1);
    run(7, 0, 0);
    chk("bad_set", 32'(bad_op), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("clr_flags", 32'({ovf_err, unf_err, bad_op}), 0);
    step(1, 1, 5, 0, 0, 1);
    chk("set_dom", 32'(unf_err), 1);
    run(6, 0, 0);
    // 6: reset beats a call mid-sequence
    for (int i = 0; i < 5; i++) run(4, 0, 6'(8 * i + 1));
    run(5, 0, 0); run(5, 0, 0);
    chk("pre_rst_depth", 32'(depth), 2);
    step(0, 1, 4, 0, 33, 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_flags", 32'({ovf_err, unf_err, bad_op}), 0);
    run(0, 0, 0);
    chk("post_rst_inc", 32'(pc), 1);
    // random mix against the model
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 40) != 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 6'($urandom), 6'($urandom),
           ($urandom_range(0, 9) == 0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
